// File: rtl/vc_cleaner.sv
// vc_cleaner: turns a raw VC request vector into a one-hot pick of the lowest-index set VC.
// Latency: 1 cycle (vc_in sampled on an edge shows on the outputs after that edge).
// Backpressure: none; a new result is produced every cycle and held until the next edge.
//
// Ports:
//   clk      - single clock; all state updates on the rising edge
//   rst      - synchronous, active-high reset; clears all outputs and dominates vc_in
//   vc_in    - raw VC request vector; any combination of bits may be set
//   vc_out   - one-hot at the lowest set bit of vc_in, or all zero
//   vc_valid - high when vc_out is non-zero
//   vc_idx   - binary index of the bit set in vc_out; 0 when vc_valid is low
module vc_cleaner #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] vc_in,
  output logic [WIDTH-1:0] vc_out,
  output logic             vc_valid,
  output logic [IDX_W-1:0] vc_idx
);

  logic [WIDTH-1:0] pick_dat;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  // Isolate the lowest set bit: two's-complement negation flips every bit
  // above the lowest one, so the AND keeps only that bit.
  always_comb begin
    pick_dat = vc_in & (~vc_in + WIDTH'(1));
    pick_vld = |vc_in;
  end

  // Index of the lowest set bit. Scanning from the top down lets the lowest
  // index be the last assignment, giving bit 0 the highest priority. The
  // index stays 0 when nothing is set.
  always_comb begin
    pick_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vc_in[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end

  // All three outputs are registered together from the same sampled vc_in,
  // so they are mutually consistent every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vc_out   <= '0;
      vc_valid <= 1'b0;
      vc_idx   <= '0;
    end else begin
      vc_out   <= pick_dat;
      vc_valid <= pick_vld;
      vc_idx   <= pick_idx;
    end
  end

endmodule

// File: tb/tb_vc_cleaner.sv
// tb_vc_cleaner: directed, exhaustive and random stimulus for vc_cleaner against a reference model.
// Latency: checks outputs 1 ns after the edge that sampled each stimulus value.
// Backpressure: none; the design never stalls.
module tb_vc_cleaner;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] vc_in;
  logic [WIDTH-1:0] vc_out;
  logic             vc_valid;
  logic [IDX_W-1:0] vc_idx;

  int passed = 0;
  int total  = 0;
  bit mon_en = 1'b0;

  vc_cleaner #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .vc_in    (vc_in),
    .vc_out   (vc_out),
    .vc_valid (vc_valid),
    .vc_idx   (vc_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: v ^ (v-1) has ones from bit 0 up to and including the lowest
  // set bit of v, so its popcount minus one is that bit's index.
  function automatic int model_idx(input logic [WIDTH-1:0] v);
    if (v == '0) return 0;
    return $countones(v ^ (v - WIDTH'(1))) - 1;
  endfunction

  function automatic logic [WIDTH-1:0] model_out(input logic [WIDTH-1:0] v);
    if (v == '0) return '0;
    return WIDTH'(1) << model_idx(v);
  endfunction

  // Apply one input value / reset level, let one rising edge sample it, and
  // return 1 ns later with the outputs settled.
  task automatic step(input logic [WIDTH-1:0] v, input logic r);
    vc_in = v;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] e_out,
                       input logic e_vld, input logic [IDX_W-1:0] e_idx);
    total++;
    assert (vc_out === e_out) begin
      passed++;
    end else begin
      $error("FAIL %s vc_out: got %h expected %h", tag, vc_out, e_out);
    end
    total++;
    assert (vc_valid === e_vld) begin
      passed++;
    end else begin
      $error("FAIL %s vc_valid: got %b expected %b", tag, vc_valid, e_vld);
    end
    total++;
    assert (vc_idx === e_idx) begin
      passed++;
    end else begin
      $error("FAIL %s vc_idx: got %0d expected %0d", tag, vc_idx, e_idx);
    end
  endtask

  // Check a sampled value against the model (reset forces all zeros).
  task automatic run_model(input string tag, input logic [WIDTH-1:0] v, input logic r);
    step(v, r);
    if (r) check(tag, '0, 1'b0, '0);
    else   check(tag, model_out(v), v != '0, IDX_W'(model_idx(v)));
  endtask

  // Output consistency invariant, sampled on every falling edge once reset
  // has defined the outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [WIDTH-1:0] exp_oh;
      exp_oh = vc_valid ? (WIDTH'(1) << vc_idx) : '0;
      total++;
      assert (vc_out === exp_oh && $countones(vc_out) <= 1 && vc_valid === (|vc_out)) begin
        passed++;
      end else begin
        $error("FAIL invariant: vc_out=%h vc_valid=%b vc_idx=%0d", vc_out, vc_valid, vc_idx);
      end
    end
  end

  initial begin
    vc_in = '0;
    rst   = 1'b1;

    // Reset dominates an all-ones input for two cycles.
    step(8'hFF, 1'b1);
    check("reset_c0", 8'h00, 1'b0, 3'd0);
    step(8'hFF, 1'b1);
    check("reset_c1", 8'h00, 1'b0, 3'd0);
    mon_en = 1'b1;

    // Basic sequence.
    step(8'h00, 1'b0); check("basic_00", 8'h00, 1'b0, 3'd0);
    step(8'h01, 1'b0); check("basic_01", 8'h01, 1'b1, 3'd0);
    step(8'h02, 1'b0); check("basic_02", 8'h02, 1'b1, 3'd1);
    step(8'h84, 1'b0); check("basic_84", 8'h04, 1'b1, 3'd2);
    step(8'h02, 1'b0); check("basic_02b", 8'h02, 1'b1, 3'd1);
    step(8'h01, 1'b0); check("basic_01b", 8'h01, 1'b1, 3'd0);
    step(8'h80, 1'b0); check("basic_80", 8'h80, 1'b1, 3'd7);

    // Multi-bit masks.
    step(8'hFF, 1'b0); check("mask_FF", 8'h01, 1'b1, 3'd0);
    step(8'hF0, 1'b0); check("mask_F0", 8'h10, 1'b1, 3'd4);
    step(8'hC0, 1'b0); check("mask_C0", 8'h40, 1'b1, 3'd6);

    // Latency: the new input must not show before the edge that samples it.
    step(8'h00, 1'b0); check("lat_pre", 8'h00, 1'b0, 3'd0);
    vc_in = 8'h20;
    #1;
    check("lat_before_edge", 8'h00, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    check("lat_after_edge", 8'h20, 1'b1, 3'd5);

    // Mid-stream reset with a steady input.
    step(8'h08, 1'b0); check("mid_pre", 8'h08, 1'b1, 3'd3);
    step(8'h08, 1'b1); check("mid_rst", 8'h00, 1'b0, 3'd0);
    step(8'h08, 1'b0); check("mid_post", 8'h08, 1'b1, 3'd3);

    // Exhaustive sweep of every input value.
    for (int v = 0; v < 256; v++) begin
      run_model("exhaustive", WIDTH'(v), 1'b0);
    end

    // Random values with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] rv;
      logic             rr;
      rv = WIDTH'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      run_model("random", rv, rr);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
